// File: rtl/btree_noc4_pkg.sv
// Shared constants and packet helpers for the four-port binary-tree NoC.
package btree_noc4_pkg;
  localparam int DataWidth  = 32;
  localparam int NumPe      = 4;
  localparam int AddrWidth  = 2;
  localparam int TW         = DataWidth + AddrWidth;
  localparam int NumSwPorts = 3;
  localparam logic [1:0] LinkPort = 2'd2;

  typedef logic [AddrWidth-1:0] addr_t;

  typedef struct packed {
    addr_t                 dest;
    logic [DataWidth-1:0]  payload;
  } pkt_t;

  function automatic addr_t pkt_dest(input logic [TW-1:0] pkt);
    return pkt[TW-1:DataWidth];
  endfunction

  // Modulo-3 wrap for port indices; inputs never exceed 4.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction
endpackage

// File: rtl/btree_leaf_switch.sv
// Leaf switch: three 2-deep input FIFOs, address routing, round-robin
// arbitration and a registered stage per output (ports 0/1 = PEs, 2 = link).
module btree_leaf_switch
  import btree_noc4_pkg::*;
#(
  parameter logic SwitchId = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NumSwPorts-1:0][TW-1:0]   in_data,
  input  logic [NumSwPorts-1:0]           in_valid,
  output logic [NumSwPorts-1:0]           in_ready,
  output logic [NumSwPorts-1:0][TW-1:0]   out_data,
  output logic [NumSwPorts-1:0]           out_valid,
  input  logic [NumSwPorts-1:0]           out_ready
);
  logic [NumSwPorts-1:0][TW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [NumSwPorts-1:0][1:0]            cnt_q, cnt_d;
  logic [NumSwPorts-1:0]                 rdy_q, rdy_d;
  logic [NumSwPorts-1:0]                 push, pop;
  logic [NumSwPorts-1:0][1:0]            route;
  logic [NumSwPorts-1:0][NumSwPorts-1:0] req;
  logic [NumSwPorts-1:0][1:0]            win;
  logic [NumSwPorts-1:0][1:0]            ptr_q, ptr_d;
  logic [NumSwPorts-1:0][TW-1:0]         od_q, od_d;
  logic [NumSwPorts-1:0]                 ov_q, ov_d;

  // Link-in traffic only ever targets a local PE, so the tree cannot loop.
  function automatic logic [1:0] route_of(input logic [TW-1:0] pkt, input logic from_link);
    addr_t dest;
    dest = pkt_dest(pkt);
    if (!from_link && (dest[1] != SwitchId)) return LinkPort;
    return {1'b0, dest[0]};
  endfunction

  function automatic logic [1:0] rr_pick(input logic [NumSwPorts-1:0] r, input logic [1:0] ptr);
    logic [1:0] idx, pick;
    pick = ptr;
    for (int k = NumSwPorts - 1; k >= 0; k--) begin
      idx = wrap3({1'b0, ptr} + 3'(k));
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign in_ready  = rdy_q;
  assign out_data  = od_q;
  assign out_valid = ov_q;
  assign push      = in_valid & rdy_q;

  always_comb begin
    route = '0;
    req   = '0;
    win   = '0;
    for (int i = 0; i < NumSwPorts; i++)
      route[i] = route_of(head_q[i], i == NumSwPorts - 1);
    for (int o = 0; o < NumSwPorts; o++) begin
      for (int i = 0; i < NumSwPorts; i++)
        req[o][i] = (cnt_q[i] != 2'd0) && (route[i] == 2'(o));
      win[o] = rr_pick(req[o], ptr_q[o]);
    end
  end

  // An output reloads when empty or when its word leaves this cycle.
  always_comb begin
    pop   = '0;
    ptr_d = ptr_q;
    od_d  = od_q;
    ov_d  = ov_q;
    for (int o = 0; o < NumSwPorts; o++) begin
      if (!ov_q[o] || out_ready[o]) begin
        if (|req[o]) begin
          ov_d[o]       = 1'b1;
          od_d[o]       = head_q[win[o]];
          pop[win[o]]   = 1'b1;
          ptr_d[o]      = wrap3({1'b0, win[o]} + 3'd1);
        end else begin
          ov_d[o] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    rdy_d  = rdy_q;
    for (int i = 0; i < NumSwPorts; i++) begin
      case ({push[i], pop[i]})
        2'b10: begin
          if (cnt_q[i] == 2'd0) head_d[i] = in_data[i];
          else                  tail_d[i] = in_data[i];
          cnt_d[i] = cnt_q[i] + 2'd1;
        end
        2'b01: begin
          head_d[i] = tail_q[i];
          cnt_d[i]  = cnt_q[i] - 2'd1;
        end
        2'b11: begin
          if (cnt_q[i] == 2'd2) begin
            head_d[i] = tail_q[i];
            tail_d[i] = in_data[i];
          end else begin
            head_d[i] = in_data[i];
          end
        end
        default: ;
      endcase
      rdy_d[i] = (cnt_d[i] != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rdy_q  <= '0;
      ptr_q  <= '0;
      od_q   <= '0;
      ov_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      ptr_q  <= ptr_d;
      od_q   <= od_d;
      ov_q   <= ov_d;
    end
  end
endmodule

// File: rtl/btree_noc4.sv
// Four-port tree NoC: two leaf switches joined by a direct bidirectional link.
module btree_noc4
  import btree_noc4_pkg::*;
(
  input  logic          clk_100,
  input  logic          i_reset,
  input  logic [TW-1:0] i_pe_data0,
  input  logic [TW-1:0] i_pe_data1,
  input  logic [TW-1:0] i_pe_data2,
  input  logic [TW-1:0] i_pe_data3,
  input  logic          i_pe_data_valid0,
  input  logic          i_pe_data_valid1,
  input  logic          i_pe_data_valid2,
  input  logic          i_pe_data_valid3,
  output logic          o_pe_data_ready0,
  output logic          o_pe_data_ready1,
  output logic          o_pe_data_ready2,
  output logic          o_pe_data_ready3,
  output logic [TW-1:0] o_pe_data0,
  output logic [TW-1:0] o_pe_data1,
  output logic [TW-1:0] o_pe_data2,
  output logic [TW-1:0] o_pe_data3,
  output logic          o_pe_data_valid0,
  output logic          o_pe_data_valid1,
  output logic          o_pe_data_valid2,
  output logic          o_pe_data_valid3,
  input  logic          i_pe_data_ready0,
  input  logic          i_pe_data_ready1,
  input  logic          i_pe_data_ready2,
  input  logic          i_pe_data_ready3
);
  logic [NumSwPorts-1:0][TW-1:0] s0_in_data, s1_in_data, s0_out_data, s1_out_data;
  logic [NumSwPorts-1:0]         s0_in_valid, s1_in_valid, s0_in_ready, s1_in_ready;
  logic [NumSwPorts-1:0]         s0_out_valid, s1_out_valid, s0_out_ready, s1_out_ready;

  // Each switch's link-out register feeds the other switch's link-in FIFO.
  assign s0_in_data   = {s1_out_data[LinkPort], i_pe_data1, i_pe_data0};
  assign s0_in_valid  = {s1_out_valid[LinkPort], i_pe_data_valid1, i_pe_data_valid0};
  assign s0_out_ready = {s1_in_ready[LinkPort], i_pe_data_ready1, i_pe_data_ready0};
  assign s1_in_data   = {s0_out_data[LinkPort], i_pe_data3, i_pe_data2};
  assign s1_in_valid  = {s0_out_valid[LinkPort], i_pe_data_valid3, i_pe_data_valid2};
  assign s1_out_ready = {s0_in_ready[LinkPort], i_pe_data_ready3, i_pe_data_ready2};

  assign o_pe_data_ready0 = s0_in_ready[0];
  assign o_pe_data_ready1 = s0_in_ready[1];
  assign o_pe_data_ready2 = s1_in_ready[0];
  assign o_pe_data_ready3 = s1_in_ready[1];
  assign o_pe_data0       = s0_out_data[0];
  assign o_pe_data1       = s0_out_data[1];
  assign o_pe_data2       = s1_out_data[0];
  assign o_pe_data3       = s1_out_data[1];
  assign o_pe_data_valid0 = s0_out_valid[0];
  assign o_pe_data_valid1 = s0_out_valid[1];
  assign o_pe_data_valid2 = s1_out_valid[0];
  assign o_pe_data_valid3 = s1_out_valid[1];

  btree_leaf_switch #(.SwitchId(1'b0)) u_sw0 (
    .clk       (clk_100),
    .rst_n     (i_reset),
    .in_data   (s0_in_data),
    .in_valid  (s0_in_valid),
    .in_ready  (s0_in_ready),
    .out_data  (s0_out_data),
    .out_valid (s0_out_valid),
    .out_ready (s0_out_ready)
  );

  btree_leaf_switch #(.SwitchId(1'b1)) u_sw1 (
    .clk       (clk_100),
    .rst_n     (i_reset),
    .in_data   (s1_in_data),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .out_data  (s1_out_data),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready)
  );
endmodule

// File: tb/tb_btree_noc4.sv
// Bench for btree_noc4: per (dest,source) expectation queues checked on every cycle.
module tb_btree_noc4;
  import btree_noc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [TW-1:0] pe_d[4];
  logic          pe_v[4];
  logic          out_rdy[4];
  logic [TW-1:0] o_d[4];
  logic          o_v[4];
  logic          o_r[4];

  btree_noc4 dut (
    .clk_100(clk), .i_reset(rst_n),
    .i_pe_data0(pe_d[0]), .i_pe_data1(pe_d[1]), .i_pe_data2(pe_d[2]), .i_pe_data3(pe_d[3]),
    .i_pe_data_valid0(pe_v[0]), .i_pe_data_valid1(pe_v[1]),
    .i_pe_data_valid2(pe_v[2]), .i_pe_data_valid3(pe_v[3]),
    .o_pe_data_ready0(o_r[0]), .o_pe_data_ready1(o_r[1]),
    .o_pe_data_ready2(o_r[2]), .o_pe_data_ready3(o_r[3]),
    .o_pe_data0(o_d[0]), .o_pe_data1(o_d[1]), .o_pe_data2(o_d[2]), .o_pe_data3(o_d[3]),
    .o_pe_data_valid0(o_v[0]), .o_pe_data_valid1(o_v[1]),
    .o_pe_data_valid2(o_v[2]), .o_pe_data_valid3(o_v[3]),
    .i_pe_data_ready0(out_rdy[0]), .i_pe_data_ready1(out_rdy[1]),
    .i_pe_data_ready2(out_rdy[2]), .i_pe_data_ready3(out_rdy[3])
  );

  int checks = 0, failures = 0;
  int cyc = 0, rst_edges = 0;
  logic [TW-1:0] exp_q[16][$];   // index dest*4 + source
  logic [TW-1:0] src_q[4][$];
  logic          will_acc[4];
  int            acc_edge[4], del_edge[4], del_cnt[4], vcnt[4];
  logic [TW-1:0] last_del[4];
  logic          hold[4];
  logic [TW-1:0] hold_d[4];
  logic          force_lo[4];
  int            rdy_pct = 100, vld_pct = 100;
  int            last_src1 = -1, switches1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) rst_edges++;
  end

  // Compare process: inputs are stable at negedge, so valid&ready here means
  // a transfer on the coming rising edge (edge number cyc+1).
  initial begin
    int  qi;
    int  src;
    bit  found;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          will_acc[k] = 1'b0;
          hold[k]     = 1'b0;
          if (rst_edges > 0) begin
            chk("rst_valid", 64'(o_v[k]), 64'd0);
            chk("rst_ready", 64'(o_r[k]), 64'd0);
            chk("rst_data",  64'(o_d[k]), 64'd0);
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          will_acc[k] = pe_v[k] && o_r[k];
          if (will_acc[k]) begin
            qi = int'(pe_d[k][TW-1:DataWidth]) * 4 + k;
            exp_q[qi].push_back(pe_d[k]);
            acc_edge[k] = cyc + 1;
          end
        end
        for (int d = 0; d < 4; d++) begin
          if (o_v[d]) vcnt[d]++;
          if (hold[d]) begin
            chk("hold_valid", 64'(o_v[d]), 64'd1);
            chk("hold_data",  64'(o_d[d]), 64'(hold_d[d]));
          end
          if (o_v[d] && out_rdy[d]) begin
            found = 1'b0;
            src   = -1;
            for (int s = 0; s < 4; s++) begin
              qi = d * 4 + s;
              if (!found && exp_q[qi].size() > 0 && exp_q[qi][0] == o_d[d]) begin
                found = 1'b1;
                src   = s;
                void'(exp_q[qi].pop_front());
              end
            end
            checks++;
            if (!found) begin
              failures++;
              $display("FAIL deliver pe%0d got=%h exp=head of a source queue", d, o_d[d]);
            end
            del_cnt[d]++;
            del_edge[d] = cyc + 1;
            last_del[d] = o_d[d];
            if (d == 1) begin
              if (last_src1 >= 0 && src != last_src1) switches1++;
              last_src1 = src;
            end
          end
          hold[d]   = o_v[d] && !out_rdy[d];
          hold_d[d] = o_d[d];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (will_acc[k]) begin
        void'(src_q[k].pop_front());
        pe_v[k] = 1'b0;
      end
      if (!pe_v[k] && src_q[k].size() > 0 && $urandom_range(99) < vld_pct) begin
        pe_v[k] = 1'b1;
        pe_d[k] = src_q[k][0];
      end
      out_rdy[k] = !force_lo[k] && ($urandom_range(99) < rdy_pct);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 16; i++) n += exp_q[i].size();
    for (int k = 0; k < 4; k++) n += src_q[k].size() + int'(pe_v[k]);
    return n;
  endfunction

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (pending() > 0 && n < bound) begin
      step();
      n++;
    end
    chk(name, 64'(pending()), 64'd0);
  endtask

  function automatic logic [TW-1:0] mk(input int dst, input int src, input int seq);
    return {2'(dst), 2'(src), 30'(seq)};
  endfunction

  initial begin
    int base, drop_at;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pe_v[k] = 1'b0; pe_d[k] = '0; out_rdy[k] = 1'b0; force_lo[k] = 1'b0;
      acc_edge[k] = 0; del_edge[k] = 0; del_cnt[k] = 0; vcnt[k] = 0;
      will_acc[k] = 1'b0; hold[k] = 1'b0; last_del[k] = '0;
    end
    repeat (10) step();
    for (int k = 0; k < 4; k++) chk("ready_in_reset", 64'(o_r[k]), 64'd0);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) chk("ready_after_release", 64'(o_r[k]), 64'd1);

    // Local hop PE0 -> PE1.
    src_q[0].push_back({2'b01, 32'hDEADBEEF});
    drain(50, "drain_local");
    chk("lat_local", 64'(del_edge[1] - acc_edge[0]), 64'd2);
    chk("pkt_local", 64'(last_del[1]), 64'h1_DEADBEEF);
    chk("quiet_others", 64'(vcnt[0] + vcnt[2] + vcnt[3]), 64'd0);
    chk("valid_once", 64'(vcnt[1]), 64'd1);

    // Cross hop PE0 -> PE3.
    src_q[0].push_back({2'b11, 32'h00000005});
    drain(50, "drain_cross");
    chk("lat_cross", 64'(del_edge[3] - acc_edge[0]), 64'd4);
    chk("pkt_cross", 64'(last_del[3]), 64'h3_00000005);

    // PE0 and PE2 contend for PE1.
    base = del_cnt[1];
    last_src1 = -1; switches1 = 0;
    for (int i = 0; i < 8; i++) begin
      src_q[0].push_back(mk(1, 0, i));
      src_q[2].push_back(mk(1, 2, i));
    end
    drain(200, "drain_contend");
    chk("contend_count", 64'(del_cnt[1] - base), 64'd16);
    chk("rr_alternate", 64'(switches1 >= 10), 64'd1);

    // Backpressure on PE1 during a PE0 stream.
    base = del_cnt[1];
    for (int i = 0; i < 30; i++) src_q[0].push_back(mk(1, 0, 100 + i));
    repeat (6) step();
    force_lo[1] = 1'b1;
    drop_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (drop_at == 0 && !o_r[0]) drop_at = i;
    end
    chk("bp_ready_drop", 64'(drop_at > 0 && drop_at <= 4), 64'd1);
    force_lo[1] = 1'b0;
    drain(300, "drain_bp");
    chk("bp_count", 64'(del_cnt[1] - base), 64'd30);

    // Tornado with random gaps and random sink backpressure.
    base = del_cnt[0] + del_cnt[1] + del_cnt[2] + del_cnt[3];
    rdy_pct = 70; vld_pct = 70;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 100; i++) src_q[k].push_back(mk((k + 1) % 4, k, 1000 + i));
    drain(5000, "drain_tornado");
    chk("tornado_count", 64'(del_cnt[0] + del_cnt[1] + del_cnt[2] + del_cnt[3] - base), 64'd400);

    // Uniform random destinations.
    base = del_cnt[0] + del_cnt[1] + del_cnt[2] + del_cnt[3];
    rdy_pct = 50; vld_pct = 80;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 60; i++) src_q[k].push_back(mk($urandom_range(3), k, 5000 + i));
    drain(6000, "drain_random");
    chk("random_count", 64'(del_cnt[0] + del_cnt[1] + del_cnt[2] + del_cnt[3] - base), 64'd240);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
